lcd_sync_module: RTL and testbench

//  Raster timing generator for the RGB LCD panel; sits directly upstream of the pixel/ROM colour stage.

---
 rtl/lcd_timing_pkg.sv | 18 +
 rtl/lcd_sync_module_if.sv | 17 +
 rtl/lcd_axis_timer.sv | 69 ++++++
 rtl/lcd_sync_module.sv | 92 +++++++++
 tb/tb_lcd_sync_module.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared raster timing types and default 800x480 panel constants.
package lcd_timing_pkg;

  typedef enum logic [1:0] {PH_SYNC, PH_BACK, PH_ACTIVE, PH_FRONT} phase_t;

  localparam int ADDR_W    = 11;
  localparam int MAX_TOTAL = 2047;

  localparam int DEF_H_SYNC   = 48;
  localparam int DEF_H_BACK   = 88;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 40;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BACK   = 32;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 13;

endpackage

// File: rtl/lcd_sync_module_if.sv
// Raster outputs handed to the colour stage and the panel.
interface lcd_sync_module_if;
  import lcd_timing_pkg::*;

  logic              ready_sig;
  logic [ADDR_W-1:0] column_addr_sig;
  logic [ADDR_W-1:0] row_addr_sig;
  logic              frame_start;
  logic              lcd_hsync;
  logic              lcd_vsync;
  logic              lcd_de;

  modport master (output ready_sig, column_addr_sig, row_addr_sig, frame_start,
                  lcd_hsync, lcd_vsync, lcd_de);
  modport slave  (input  ready_sig, column_addr_sig, row_addr_sig, frame_start,
                  lcd_hsync, lcd_vsync, lcd_de);
endinterface

// File: rtl/lcd_axis_timer.sv
// One raster axis: wrapping counter plus SYNC/BACK/ACTIVE/FRONT phase tracker.
module lcd_axis_timer
  import lcd_timing_pkg::*;
#(
  parameter int SYNC   = 1,
  parameter int BACK   = 1,
  parameter int ACTIVE = 1,
  parameter int FRONT  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              step,
  output logic [ADDR_W-1:0] cnt,
  output phase_t            phase,
  output logic              wrap,
  output logic [ADDR_W-1:0] active_idx
);

  localparam logic [ADDR_W-1:0] LAST_SYNC   = ADDR_W'(SYNC - 1);
  localparam logic [ADDR_W-1:0] LAST_BACK   = ADDR_W'(SYNC + BACK - 1);
  localparam logic [ADDR_W-1:0] LAST_ACTIVE = ADDR_W'(SYNC + BACK + ACTIVE - 1);
  localparam logic [ADDR_W-1:0] LAST_TOTAL  = ADDR_W'(SYNC + BACK + ACTIVE + FRONT - 1);
  localparam logic [ADDR_W-1:0] ACT_OFFSET  = ADDR_W'(SYNC + BACK);

  logic [ADDR_W-1:0] r_cnt;
  phase_t            r_phase;
  phase_t            w_phase_nxt;
  logic [ADDR_W-1:0] w_last;

  assign wrap = step && (r_cnt == LAST_TOTAL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (step) begin
      r_cnt <= wrap ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_phase <= PH_SYNC;
    else       r_phase <= w_phase_nxt;
  end

  // Phase moves on when the counter sits on that phase's last count.
  always_comb begin
    w_last      = LAST_SYNC;
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_SYNC:   w_last = LAST_SYNC;
      PH_BACK:   w_last = LAST_BACK;
      PH_ACTIVE: w_last = LAST_ACTIVE;
      default:   w_last = LAST_TOTAL;
    endcase
    if (step && (r_cnt == w_last)) begin
      case (r_phase)
        PH_SYNC:   w_phase_nxt = PH_BACK;
        PH_BACK:   w_phase_nxt = PH_ACTIVE;
        PH_ACTIVE: w_phase_nxt = PH_FRONT;
        default:   w_phase_nxt = PH_SYNC;
      endcase
    end
  end

  assign cnt        = r_cnt;
  assign phase      = r_phase;
  assign active_idx = r_cnt - ACT_OFFSET;

endmodule

// File: rtl/lcd_sync_module.sv
// RGB LCD raster generator: visible-pixel addresses and delayed panel strobes.
module lcd_sync_module
  import lcd_timing_pkg::*;
#(
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_DLY = 2
) (
  input  logic               clk,
  input  logic               rstn,
  lcd_sync_module_if.master  bus
);

  localparam int   H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int   V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam logic INACT   = ~SYNC_POL;

  generate
    if (H_SYNC < 1 || H_BACK < 1 || H_ACTIVE < 1 || H_FRONT < 1 ||
        V_SYNC < 1 || V_BACK < 1 || V_ACTIVE < 1 || V_FRONT < 1 ||
        H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL ||
        PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_param
      $error("lcd_sync_module: illegal timing parameters");
    end
  endgenerate

  logic [ADDR_W-1:0] w_h_cnt, w_v_cnt, w_h_idx, w_v_idx;
  phase_t            w_h_phase, w_v_phase;
  logic              w_h_wrap, w_v_wrap;

  lcd_axis_timer #(.SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT)) u_h (
    .clk(clk), .rstn(rstn), .step(1'b1),
    .cnt(w_h_cnt), .phase(w_h_phase), .wrap(w_h_wrap), .active_idx(w_h_idx)
  );

  lcd_axis_timer #(.SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT)) u_v (
    .clk(clk), .rstn(rstn), .step(w_h_wrap),
    .cnt(w_v_cnt), .phase(w_v_phase), .wrap(w_v_wrap), .active_idx(w_v_idx)
  );

  logic w_ready, w_first, w_hs_raw, w_vs_raw;

  assign w_ready  = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);
  assign w_first  = w_ready && (w_h_idx == '0) && (w_v_idx == '0);
  // hsync is held asserted through every line of the vertical sync interval.
  assign w_hs_raw = ((w_h_phase == PH_SYNC) || (w_v_phase == PH_SYNC)) ? SYNC_POL : INACT;
  assign w_vs_raw = (w_v_phase == PH_SYNC) ? SYNC_POL : INACT;

  logic [ADDR_W-1:0] r_col, r_row;
  logic              r_fs;
  logic [PIPE_DLY:0] r_hs_sr, r_vs_sr, r_de_sr;

  // Stage 0 of each shift register is the output register; PIPE_DLY stages follow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col   <= '0;
      r_row   <= '0;
      r_fs    <= 1'b0;
      r_hs_sr <= {(PIPE_DLY+1){INACT}};
      r_vs_sr <= {(PIPE_DLY+1){INACT}};
      r_de_sr <= '0;
    end else begin
      r_col      <= w_ready ? w_h_idx : '0;
      r_row      <= w_ready ? w_v_idx : '0;
      r_fs       <= w_first;
      r_hs_sr[0] <= w_hs_raw;
      r_vs_sr[0] <= w_vs_raw;
      r_de_sr[0] <= w_ready;
      for (int i = 1; i <= PIPE_DLY; i++) begin
        r_hs_sr[i] <= r_hs_sr[i-1];
        r_vs_sr[i] <= r_vs_sr[i-1];
        r_de_sr[i] <= r_de_sr[i-1];
      end
    end
  end

  assign bus.ready_sig       = r_de_sr[0];
  assign bus.column_addr_sig = r_col;
  assign bus.row_addr_sig    = r_row;
  assign bus.frame_start     = r_fs;
  assign bus.lcd_hsync       = r_hs_sr[PIPE_DLY];
  assign bus.lcd_vsync       = r_vs_sr[PIPE_DLY];
  assign bus.lcd_de          = r_de_sr[PIPE_DLY];

endmodule

// File: tb/tb_lcd_sync_module.sv
// Bench: small-raster timing (H 2/3/8/2, V 1/2/4/1) on two configurations against a cycle-index model.
module tb_lcd_sync_module;

  localparam int HS = 2, HB = 3, HA = 8, HF = 2;
  localparam int VS = 1, VB = 2, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  lcd_sync_module_if bus_a ();
  lcd_sync_module_if bus_b ();

  lcd_sync_module #(.H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
                    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
                    .SYNC_POL(1'b0), .PIPE_DLY(2)) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a.master));

  lcd_sync_module #(.H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
                    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
                    .SYNC_POL(1'b1), .PIPE_DLY(0)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b.master));

  typedef struct {
    int ready; int col; int row; int fs; int hs; int vs; int de;
  } exp_t;

  typedef struct {
    int n; int ready; int col; int row; int fs;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n = 0;  // clock edges since reset release

  // Expected outputs for the raster position reached k clocks after release.
  function automatic exp_t model(int k, int pol);
    exp_t e;
    int h, v;
    e.ready = 0; e.col = 0; e.row = 0; e.fs = 0;
    e.hs = 1 - pol; e.vs = 1 - pol; e.de = 0;
    if (k >= 0) begin
      h = k % HT;
      v = (k / HT) % VT;
      e.ready = (h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA) ? 1 : 0;
      if (e.ready == 1) begin
        e.col = h - (HS + HB);
        e.row = v - (VS + VB);
      end
      e.fs = (e.ready == 1 && e.col == 0 && e.row == 0) ? 1 : 0;
      e.hs = (h < HS || v < VS) ? pol : 1 - pol;
      e.vs = (v < VS) ? pol : 1 - pol;
      e.de = e.ready;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s n=%0d got %0d expected %0d", name, n, act, expv);
    end
  endtask

  task automatic check_all();
    exp_t ea, eda, eb;
    ea  = model(n - 1, 0);
    eda = model(n - 3, 0);
    eb  = model(n - 1, 1);
    chk("a.ready", int'(bus_a.ready_sig), ea.ready);
    chk("a.col",   int'(bus_a.column_addr_sig), ea.col);
    chk("a.row",   int'(bus_a.row_addr_sig), ea.row);
    chk("a.fs",    int'(bus_a.frame_start), ea.fs);
    chk("a.hsync", int'(bus_a.lcd_hsync), eda.hs);
    chk("a.vsync", int'(bus_a.lcd_vsync), eda.vs);
    chk("a.de",    int'(bus_a.lcd_de), eda.de);
    chk("b.ready", int'(bus_b.ready_sig), eb.ready);
    chk("b.col",   int'(bus_b.column_addr_sig), eb.col);
    chk("b.row",   int'(bus_b.row_addr_sig), eb.row);
    chk("b.fs",    int'(bus_b.frame_start), eb.fs);
    chk("b.hsync", int'(bus_b.lcd_hsync), eb.hs);
    chk("b.vsync", int'(bus_b.lcd_vsync), eb.vs);
    chk("b.de",    int'(bus_b.lcd_de), eb.de);
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn) n++;
    @(negedge clk);
    check_all();
  endtask

  task automatic assert_reset_now();
    rstn = 1'b0;
    #1;
    n = 0;
    check_all();
  endtask

  vec_t tbl[9];
  int   cnt_ready, cnt_fs, cnt_vs_a, cnt_vs_b, cnt_hs_a, cnt_hs_b;
  int   rd_d1, rd_d2;
  bit   found;

  initial begin
    tbl[0] = '{50,  0, 0, 0, 0};
    tbl[1] = '{51,  1, 0, 0, 1};
    tbl[2] = '{52,  1, 1, 0, 0};
    tbl[3] = '{58,  1, 7, 0, 0};
    tbl[4] = '{59,  0, 0, 0, 0};
    tbl[5] = '{66,  1, 0, 1, 0};
    tbl[6] = '{101, 1, 5, 3, 0};
    tbl[7] = '{106, 0, 0, 0, 0};
    tbl[8] = '{171, 1, 0, 0, 1};

    // Reset state
    rstn = 1'b0;
    repeat (3) step();
    chk("rst.hsync_a_inactive", int'(bus_a.lcd_hsync), 1);
    chk("rst.hsync_b_inactive", int'(bus_b.lcd_hsync), 0);
    rstn = 1'b1;
    n = 0;

    // Fixed checkpoints after release
    for (int i = 0; i < 9; i++) begin
      while (n < tbl[i].n) step();
      chk("tbl.ready", int'(bus_a.ready_sig), tbl[i].ready);
      chk("tbl.col",   int'(bus_a.column_addr_sig), tbl[i].col);
      chk("tbl.row",   int'(bus_a.row_addr_sig), tbl[i].row);
      chk("tbl.fs",    int'(bus_a.frame_start), tbl[i].fs);
    end

    // One full frame of aggregate counts, plus direct de-vs-ready delay
    cnt_ready = 0; cnt_fs = 0; cnt_vs_a = 0; cnt_vs_b = 0; cnt_hs_a = 0; cnt_hs_b = 0;
    rd_d1 = int'(bus_a.ready_sig);
    step();
    rd_d2 = rd_d1; rd_d1 = int'(bus_a.ready_sig);
    for (int c = 0; c < HT * VT; c++) begin
      step();
      chk("a.de_vs_ready_d2", int'(bus_a.lcd_de), rd_d2);
      chk("b.de_eq_ready", int'(bus_b.lcd_de), int'(bus_b.ready_sig));
      rd_d2 = rd_d1; rd_d1 = int'(bus_a.ready_sig);
      cnt_ready += int'(bus_a.ready_sig);
      cnt_fs    += int'(bus_a.frame_start);
      cnt_vs_a  += (bus_a.lcd_vsync == 1'b0) ? 1 : 0;
      cnt_vs_b  += (bus_b.lcd_vsync == 1'b1) ? 1 : 0;
      cnt_hs_a  += (bus_a.lcd_hsync == 1'b0) ? 1 : 0;
      cnt_hs_b  += (bus_b.lcd_hsync == 1'b1) ? 1 : 0;
    end
    chk("frame.ready_count", cnt_ready, VA * HA);
    chk("frame.fs_count", cnt_fs, 1);
    chk("frame.vsync_a_low", cnt_vs_a, VS * HT);
    chk("frame.vsync_b_high", cnt_vs_b, VS * HT);
    chk("frame.hsync_a_low", cnt_hs_a, VS * HT + (VT - VS) * HS);
    chk("frame.hsync_b_high", cnt_hs_b, VS * HT + (VT - VS) * HS);

    // Reset mid-row 2, col 5
    found = 1'b0;
    for (int c = 0; c < 2 * HT * VT && !found; c++) begin
      step();
      if (bus_a.ready_sig && bus_a.row_addr_sig == 11'd2 && bus_a.column_addr_sig == 11'd5)
        found = 1'b1;
    end
    chk("midreset.found_row2_col5", int'(found), 1);
    assert_reset_now();
    chk("midreset.ready_low", int'(bus_a.ready_sig), 0);
    chk("midreset.de_low", int'(bus_a.lcd_de), 0);
    repeat (2) step();
    rstn = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step();
      if (bus_a.ready_sig) found = 1'b1;
    end
    chk("midreset.first_ready_clk", n, 51);
    chk("midreset.first_fs", int'(bus_a.frame_start), 1);

    // Random run lengths with random reset pulses
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 400)) step();
      assert_reset_now();
      repeat ($urandom_range(1, 3)) step();
      rstn = 1'b1;
    end
    repeat (200) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
